// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   state_t  : sequencer states (IDLE, RUN, DONE)
//   NIBBLE_W : width of the time-shared adder slice
package nibble_serial_addsub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : nibble_serial_addsub_pkg

// File: rtl/nibble_serial_addsub_rca4.sv
// 4-bit ripple-carry adder slice.
//   carryin  : carry into bit 0
//   X, Y     : 4-bit addends
//   S        : 4-bit sum
//   carryout : carry out of bit 3
module nibble_serial_addsub_rca4 (
  input  logic       carryin,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic [3:0] S,
  output logic       carryout
);

  logic [4:0] w_c;

  assign w_c[0] = carryin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]     = X[i] ^ Y[i] ^ w_c[i];
    assign w_c[i+1] = (X[i] & Y[i]) | (w_c[i] & (X[i] ^ Y[i]));
  end

  assign carryout = w_c[4];

endmodule : nibble_serial_addsub_rca4

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial WIDTH-bit add/subtract: one 4-bit adder slice is reused
// once per clock, LSB nibble first, with the inter-nibble carry registered.
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset
//   start     : request, honoured in IDLE or DONE only
//   sub       : 0 = A+B, 1 = A-B (sampled with start)
//   A, B      : WIDTH-bit operands (sampled with start)
//   busy      : high while nibbles are being processed
//   done      : one-cycle pulse when S/carryout/overflow are final
//   S         : result, valid from done until the next accepted start
//   carryout  : final carry (subtract: 1 = no borrow)
//   overflow  : two's-complement overflow of the full-width operation
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned WIDTH   = 4 * NIBBLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             carryout,
  output logic             overflow
);

  localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_opa;
  logic [WIDTH-1:0]      r_opb;
  logic                  r_carry;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_s;
  logic                  r_cout;
  logic                  r_ovf;

  logic [NIBBLE_W-1:0]   w_x;
  logic [NIBBLE_W-1:0]   w_y;
  logic [NIBBLE_W-1:0]   w_sum;
  logic                  w_cout;
  logic                  w_last;
  logic                  w_accept;

  assign w_last   = (r_cnt == CNT_W'(NIBBLES - 1));
  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Nibble mux: select the operand slice addressed by the counter.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_x = r_opa[k*NIBBLE_W +: NIBBLE_W];
        w_y = r_opb[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_serial_addsub_rca4 u_rca4 (
    .carryin  (r_carry),
    .X        (w_x),
    .Y        (w_y),
    .S        (w_sum),
    .carryout (w_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B here, inject the 1 as carry-in.
      r_opa   <= A;
      r_opb   <= sub ? ~B : B;
      r_carry <= sub;
      r_cnt   <= '0;
      r_s     <= '0;
    end else if (r_state == ST_RUN) begin
      for (int unsigned k = 0; k < NIBBLES; k++) begin
        if (r_cnt == CNT_W'(k)) begin
          r_s[k*NIBBLE_W +: NIBBLE_W] <= w_sum;
        end
      end
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_cout <= w_cout;
        // On the last nibble w_x/w_y hold the operand sign bits.
        r_ovf  <= (w_x[NIBBLE_W-1] == w_y[NIBBLE_W-1]) &&
                  (w_sum[NIBBLE_W-1] != w_x[NIBBLE_W-1]);
      end
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);
  assign S        = r_s;
  assign carryout = r_cout;
  assign overflow = r_ovf;

endmodule : nibble_serial_addsub

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned TIMEOUT = 20;

  logic             clock;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             carryout;
  logic             overflow;

  int unsigned n_checks;
  int unsigned n_fail;

  nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .S        (S),
    .carryout (carryout),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until done or timeout; returns number of edges taken.
  task automatic wait_done(output int unsigned edges);
    edges = 0;
    while (!done && edges < TIMEOUT) begin
      tick();
      edges++;
    end
  endtask

  // Full directed operation: start for one cycle, wait for done, check results.
  task automatic do_op(input string tag, input logic s, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_s,
                       input logic exp_c, input logic exp_v);
    int unsigned edges;
    sub = s; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(edges);
    check({tag, "_lat"}, edges, 32'd4);
    check({tag, "_S"}, 32'(S), 32'(exp_s));
    check({tag, "_cout"}, 32'(carryout), 32'(exp_c));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_v));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_S_hold"}, 32'(S), 32'(exp_s));
  endtask

  initial begin
    int unsigned edges;
    int unsigned pulses;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_S", 32'(S), 32'd0);
    check("rst_cout", 32'(carryout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    tick();

    do_op("add1", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
    do_op("add2", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    do_op("add3", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    do_op("sub1", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub2", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub3", 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0);

    // start pulsed during RUN must be ignored
    sub = 1'b0; A = 16'h0001; B = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        check("ign_S", 32'(S), 32'h0002);
      end
      tick();
    end
    check("ign_pulses", pulses, 32'd1);

    // reset in the second RUN cycle aborts the operation (prior op left carryout=0; set it to 1 first)
    do_op("pre_rst", 1'b1, 16'h0003, 16'h0001, 16'h0002, 1'b1, 1'b0);
    sub = 1'b0; A = 16'h0FFF; B = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_S", 32'(S), 32'd0);
    check("abort_cout", 32'(carryout), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      tick();
    end
    check("abort_pulses", pulses, 32'd0);
    do_op("post_rst", 1'b0, 16'h00F0, 16'h0F10, 16'h1000, 1'b0, 1'b0);

    // start held through DONE: back-to-back operations
    sub = 1'b0; A = 16'h0101; B = 16'h0202; start = 1'b1;
    tick();
    A = 16'hA000; B = 16'h6000;
    wait_done(edges);
    check("b2b_lat1", edges, 32'd4);
    check("b2b_S1", 32'(S), 32'h0303);
    check("b2b_cout1", 32'(carryout), 32'd0);
    tick();
    check("b2b_busy", 32'(busy), 32'd1);
    edges = 1;
    while (!done && edges < TIMEOUT) begin
      tick();
      edges++;
    end
    start = 1'b0;
    check("b2b_gap", edges, 32'd5);
    check("b2b_S2", 32'(S), 32'h0000);
    check("b2b_cout2", 32'(carryout), 32'd1);
    check("b2b_ovf2", 32'(overflow), 32'd0);
    tick();
    check("b2b_idle", 32'(busy | done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_nibble_serial_addsub
